// File: rtl/audio_mixer_ring_pkg.sv
// Shared types for the audio mixer ring: sample type, mixer state encoding and
// the accumulator width rule used by the top level.
package audio_mixer_pkg;

  localparam int SAMPLE_BITS_DEFAULT = 16;

  typedef logic signed [SAMPLE_BITS_DEFAULT-1:0] sample_t;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_ACCUM,
    ST_MASTER,
    ST_WRITE
  } mix_state_t;

  // Wide enough that NUM_CH full-scale terms at maximum gain, then master gain, never overflow
  function automatic int acc_width(input int sample_bits, input int volume_bits, input int num_ch);
    return sample_bits + volume_bits + $clog2(num_ch) + 1;
  endfunction

endpackage

// File: rtl/audio_mixer_ring_if.sv
// Bus between the mix controller/player and the mixer ring: channel inputs,
// mix request, buffer read port and status flags.
interface audio_mixer_ring_if #(
  parameter int NUM_CH      = 4,
  parameter int SAMPLE_BITS = 16,
  parameter int VOLUME_BITS = 8,
  parameter int BUF_LEN     = 32
);

  logic                            tick;
  logic [NUM_CH*SAMPLE_BITS-1:0]   ch_sample;
  logic [NUM_CH-1:0]               ch_valid;
  logic [NUM_CH*VOLUME_BITS-1:0]   ch_vol;
  logic [VOLUME_BITS-1:0]          master_vol;
  logic [$clog2(BUF_LEN)-1:0]      rd_index;
  logic [SAMPLE_BITS-1:0]          rd_sample;
  logic                            busy;
  logic                            overrun;
  logic                            clip;

  modport master (
    output tick, ch_sample, ch_valid, ch_vol, master_vol, rd_index,
    input  rd_sample, busy, overrun, clip
  );

  modport slave (
    input  tick, ch_sample, ch_valid, ch_vol, master_vol, rd_index,
    output rd_sample, busy, overrun, clip
  );

endinterface

// File: rtl/audio_mixer_ring_gain.sv
// Signed x unsigned gain stage: y = (a * gain) >>> (VOL_BITS-1), so a gain of
// 2^(VOL_BITS-1) is unity and the shift floors toward minus infinity.
module mixer_gain_mul #(
  parameter int IN_BITS  = 27,
  parameter int VOL_BITS = 8,
  parameter int OUT_BITS = 27
) (
  input  logic signed [IN_BITS-1:0]  a,
  input  logic        [VOL_BITS-1:0] gain,
  output logic signed [OUT_BITS-1:0] y
);

  localparam int PW = IN_BITS + VOL_BITS + 1;

  logic signed [PW-1:0] prod;

  always_comb begin
    prod = PW'(a) * PW'($signed({1'b0, gain}));
    y    = OUT_BITS'(prod >>> (VOL_BITS - 1));
  end

endmodule

// File: rtl/audio_mixer_ring.sv
// Multi-channel mixer writing one sample per tick into a ring buffer LAG slots behind the player.
// Define MIXER_SATURATE_EN to clamp the written sample and raise clip instead of wrapping.
module audio_mixer_ring
  import audio_mixer_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SAMPLE_BITS = 16,
  parameter int VOLUME_BITS = 8,
  parameter int BUF_LEN     = 32,
  parameter int LAG         = 10
) (
  input logic              clk,
  input logic              rst,
  audio_mixer_ring_if.slave bus
);

  localparam int ACC_W = acc_width(SAMPLE_BITS, VOLUME_BITS, NUM_CH);
  localparam int AW    = $clog2(BUF_LEN);
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  mix_state_t                     state;
  logic [NUM_CH*SAMPLE_BITS-1:0]  snap_sample;
  logic [NUM_CH-1:0]              snap_valid;
  logic [NUM_CH*VOLUME_BITS-1:0]  snap_vol;
  logic [VOLUME_BITS-1:0]         snap_master;
  logic [AW-1:0]                  wr_addr;
  logic [AW-1:0]                  clr_addr;
  logic [CW-1:0]                  ch_idx;
  logic signed [ACC_W-1:0]        acc;
  logic signed [ACC_W-1:0]        mul_a;
  logic signed [ACC_W-1:0]        mul_y;
  logic [VOLUME_BITS-1:0]         mul_gain;
  logic signed [SAMPLE_BITS-1:0]  cur_sample;
  logic [SAMPLE_BITS-1:0]         write_val;
  logic                           clip_now;
  logic                           mem_we;
  logic [AW-1:0]                  mem_addr;
  logic [SAMPLE_BITS-1:0]         mem_wdata;
  logic [SAMPLE_BITS-1:0]         mem [BUF_LEN];
  logic [SAMPLE_BITS-1:0]         rd_q;
  logic                           overrun_q;
  logic                           clip_q;

  // One multiplier serves both the per-channel terms and the master gain pass
  always_comb begin
    cur_sample = $signed(snap_sample[ch_idx*SAMPLE_BITS +: SAMPLE_BITS]);
    if (state == ST_ACCUM) begin
      mul_a    = ACC_W'(cur_sample);
      mul_gain = snap_vol[ch_idx*VOLUME_BITS +: VOLUME_BITS];
    end else begin
      mul_a    = acc;
      mul_gain = snap_master;
    end
  end

  mixer_gain_mul #(
    .IN_BITS (ACC_W),
    .VOL_BITS(VOLUME_BITS),
    .OUT_BITS(ACC_W)
  ) u_gain (
    .a   (mul_a),
    .gain(mul_gain),
    .y   (mul_y)
  );

`ifdef MIXER_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-SAMPLE_BITS+1){1'b0}}, {(SAMPLE_BITS-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-SAMPLE_BITS+1){1'b1}}, {(SAMPLE_BITS-1){1'b0}}};

  always_comb begin
    clip_now  = 1'b0;
    write_val = acc[SAMPLE_BITS-1:0];
    if (acc > SAT_MAX) begin
      write_val = {1'b0, {(SAMPLE_BITS-1){1'b1}}};
      clip_now  = 1'b1;
    end else if (acc < SAT_MIN) begin
      write_val = {1'b1, {(SAMPLE_BITS-1){1'b0}}};
      clip_now  = 1'b1;
    end
  end
`else
  always_comb begin
    write_val = acc[SAMPLE_BITS-1:0];
    clip_now  = 1'b0;
  end
`endif

  // CLEAR and WRITE share the single write port; a reset cycle never writes
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = wr_addr;
    mem_wdata = write_val;
    if (!rst) begin
      if (state == ST_CLEAR) begin
        mem_we    = 1'b1;
        mem_addr  = clr_addr;
        mem_wdata = '0;
      end else if (state == ST_WRITE) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_q <= '0;
    else     rd_q <= mem[bus.rd_index];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_CLEAR;
      clr_addr    <= '0;
      wr_addr     <= '0;
      ch_idx      <= '0;
      acc         <= '0;
      snap_sample <= '0;
      snap_valid  <= '0;
      snap_vol    <= '0;
      snap_master <= '0;
      overrun_q   <= 1'b0;
      clip_q      <= 1'b0;
    end else begin
      if (bus.tick && (state == ST_ACCUM || state == ST_MASTER || state == ST_WRITE))
        overrun_q <= 1'b1;
      case (state)
        ST_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == AW'(BUF_LEN - 1)) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (bus.tick) begin
            snap_sample <= bus.ch_sample;
            snap_valid  <= bus.ch_valid;
            snap_vol    <= bus.ch_vol;
            snap_master <= bus.master_vol;
            wr_addr     <= bus.rd_index - AW'(LAG);
            acc         <= '0;
            ch_idx      <= '0;
            state       <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (snap_valid[ch_idx]) acc <= acc + mul_y;
          ch_idx <= ch_idx + 1'b1;
          if (ch_idx == CW'(NUM_CH - 1)) state <= ST_MASTER;
        end
        ST_MASTER: begin
          acc   <= mul_y;
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          if (clip_now) clip_q <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  assign bus.rd_sample = rd_q;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.overrun   = overrun_q;
  assign bus.clip      = clip_q;

endmodule

// File: tb/tb_audio_mixer_ring.sv
// Directed self-checking bench for audio_mixer_ring with hand-computed mix results.
module tb_audio_mixer_ring;
  import audio_mixer_pkg::*;

  localparam int NUM_CH = 4;
  localparam int SB     = 16;
  localparam int VB     = 8;
  localparam int BL     = 32;
  localparam int LAG    = 10;
  localparam int AW     = $clog2(BL);

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  audio_mixer_ring_if #(.NUM_CH(NUM_CH), .SAMPLE_BITS(SB), .VOLUME_BITS(VB), .BUF_LEN(BL)) bus ();

  audio_mixer_ring #(
    .NUM_CH(NUM_CH), .SAMPLE_BITS(SB), .VOLUME_BITS(VB), .BUF_LEN(BL), .LAG(LAG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic checkOutput(input string tag, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NUM_CH*SB-1:0] packSamples(input int s0, input int s1, input int s2, input int s3);
    return {SB'(s3), SB'(s2), SB'(s1), SB'(s0)};
  endfunction

  function automatic logic [NUM_CH*VB-1:0] packVols(input int v0, input int v1, input int v2, input int v3);
    return {VB'(v3), VB'(v2), VB'(v1), VB'(v0)};
  endfunction

  // Pulses tick for one cycle, then scrambles the inputs so only the snapshot can be used
  task automatic applyStimulus(input logic [NUM_CH*SB-1:0] smp, input logic [NUM_CH-1:0] vld,
                               input logic [NUM_CH*VB-1:0] vol, input logic [VB-1:0] mvol,
                               input logic [AW-1:0] ridx);
    bus.ch_sample  = smp;
    bus.ch_valid   = vld;
    bus.ch_vol     = vol;
    bus.master_vol = mvol;
    bus.rd_index   = ridx;
    bus.tick       = 1'b1;
    step();
    bus.tick       = 1'b0;
    bus.ch_sample  = ~smp;
    bus.ch_valid   = ~vld;
    bus.ch_vol     = ~vol;
    bus.master_vol = ~mvol;
  endtask

  task automatic expectWrite(input string tag, input logic [AW-1:0] addr,
                             input sample_t old_val, input sample_t new_val);
    bus.rd_index = addr;
    repeat (NUM_CH + 1) step();
    checkOutput({tag, " busy before write"}, bus.busy, 1);
    step();
    checkOutput({tag, " read-first"}, $signed(bus.rd_sample), old_val);
    checkOutput({tag, " idle after write"}, bus.busy, 0);
    step();
    checkOutput({tag, " data"}, $signed(bus.rd_sample), new_val);
  endtask

  task automatic readAddr(input string tag, input logic [AW-1:0] addr, input sample_t expected);
    bus.rd_index = addr;
    step();
    checkOutput(tag, $signed(bus.rd_sample), expected);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int      n;
    sample_t exp_sat;
    logic    exp_clip;

    rst            = 1'b1;
    bus.tick       = 1'b0;
    bus.ch_sample  = '0;
    bus.ch_valid   = '0;
    bus.ch_vol     = '0;
    bus.master_vol = '0;
    bus.rd_index   = '0;
    step();
    step();
    checkOutput("reset busy", bus.busy, 1);
    checkOutput("reset overrun", bus.overrun, 0);
    checkOutput("reset clip", bus.clip, 0);
    checkOutput("reset rd_sample", $signed(bus.rd_sample), 0);
    rst = 1'b0;

    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      step();
      n++;
    end
    checkOutput("clear cycles", n, BL);
    for (int i = 0; i < BL; i++) readAddr($sformatf("clear addr %0d", i), AW'(i), 0);

    applyStimulus(packSamples(1000, 0, 0, 0), 4'b0001, packVols(128, 0, 0, 0), 8'd128, 5'd15);
    expectWrite("unity ch0", 5'd5, 0, 1000);

    applyStimulus(packSamples(1000, 0, 0, -301), 4'b1001, packVols(64, 0, 0, 255), 8'd128, 5'd3);
    expectWrite("wrap addr25", 5'd25, 0, -100);

    applyStimulus(packSamples(12345, -20000, 0, 0), 4'b0010, packVols(128, 64, 0, 0), 8'd255, 5'd17);
    expectWrite("floor shift", 5'd7, 0, -19922);
    checkOutput("clip before overflow", bus.clip, 0);

`ifdef MIXER_SATURATE_EN
    exp_sat  = 16'sd32767;
    exp_clip = 1'b1;
`else
    exp_sat  = -16'sd11072;
    exp_clip = 1'b0;
`endif
    applyStimulus(packSamples(30000, 30000, 30000, 30000), 4'b1111,
                  packVols(128, 128, 128, 128), 8'd128, 5'd16);
    expectWrite("overflow", 5'd6, 0, exp_sat);
    checkOutput("overflow clip", bus.clip, exp_clip);
    checkOutput("overrun still clear", bus.overrun, 0);

    applyStimulus(packSamples(2000, 0, 0, 0), 4'b0001, packVols(128, 0, 0, 0), 8'd128, 5'd20);
    step();
    bus.tick      = 1'b1;
    bus.ch_sample = packSamples(5000, 5000, 5000, 5000);
    bus.ch_valid  = 4'b1111;
    bus.rd_index  = 5'd0;
    step();
    bus.tick = 1'b0;
    checkOutput("overrun set", bus.overrun, 1);
    bus.rd_index = 5'd10;
    repeat (3) step();
    checkOutput("overrun busy before write", bus.busy, 1);
    step();
    checkOutput("overrun read-first", $signed(bus.rd_sample), 0);
    checkOutput("overrun idle after write", bus.busy, 0);
    step();
    checkOutput("overrun first result", $signed(bus.rd_sample), 2000);
    bus.rd_index = 5'd22;
    repeat (10) step();
    checkOutput("overrun no second mix", bus.busy, 0);
    checkOutput("overrun no second write", $signed(bus.rd_sample), 0);
    checkOutput("overrun sticky", bus.overrun, 1);

    applyStimulus(packSamples(777, 0, 0, 0), 4'b0001, packVols(128, 0, 0, 0), 8'd128, 5'd15);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("midmix reset overrun", bus.overrun, 0);
    checkOutput("midmix reset clip", bus.clip, 0);
    checkOutput("midmix reset rd_sample", $signed(bus.rd_sample), 0);
    checkOutput("midmix reset busy", bus.busy, 1);
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    n = 1;
    while (bus.busy === 1'b1 && n < 100) begin
      step();
      n++;
    end
    checkOutput("midmix clear cycles", n, BL);
    checkOutput("clear tick no overrun", bus.overrun, 0);
    readAddr("cleared addr5", 5'd5, 0);
    readAddr("cleared addr6", 5'd6, 0);
    readAddr("cleared addr10", 5'd10, 0);
    readAddr("cleared addr25", 5'd25, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
